genesis_pad_scanner: RTL and testbench
======================================

Name: genesis_pad_scanner

Overview:
- Multi-port, parametrised scanner for Genesis-style 3/6-button gamepads.
- Drives one shared select line and samples all pads on every scan frame.
- Auto-detects 6-button pads, debounces button levels per pad, and produces one-cycle "pressed" pulses plus a frame strobe.
- Sits between the pad pins and the game FSM; it replaces the single-pad reader.

Parameters:
- NUM_PADS, 2: number of pads scanned in parallel; legal range 1..4.
- PHASE_CYCLES, 1000: clk cycles per select phase; must be >= 2.
- GAP_CYCLES, 12000: clk cycles of select-high idle after each frame, so 6-button pads reset their internal counter; must be >= 1.
- DEBOUNCE_FRAMES, 2: number of consecutive identical raw frames required before the debounced level updates; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_fixed  in  1  synchronous, active-low reset.
- enable  in  1  1 = scanning runs; 0 = current frame completes, then the block parks in GAP.
- PIN_UP_Z  in  NUM_PADS  per-pad pin, active low.
- PIN_DOWN_Y  in  NUM_PADS  per-pad pin, active low.
- PIN_LEFT_X  in  NUM_PADS  per-pad pin, active low.
- PIN_RIGHT_MODE  in  NUM_PADS  per-pad pin, active low.
- PIN_A_B  in  NUM_PADS  per-pad pin, active low.
- PIN_START_C  in  NUM_PADS  per-pad pin, active low.
- select  out  1  shared select line to all pads.
- buttons  out  12*NUM_PADS  debounced levels, 1 = held.
  - Pad p occupies bits [12p+11:12p].
  - Bit order within a pad, MSB to LSB: up, down, left, right, a, b, c, x, y, z, start, mode.
- pressed  out  12*NUM_PADS  one-cycle rising-edge pulses of buttons, same layout.
- six_button  out  NUM_PADS  1 = pad p answered as a 6-button pad in the last frame.
- frame_done  out  1  one-cycle strobe when the outputs update.

Behaviour:
- Reset (reset_fixed=0 at a clk edge):
  - Outputs: select=1, buttons=0, pressed=0, six_button=0, frame_done=0.
  - Internal state: FSM goes to GAP with the gap counter loaded so that GAP exits on the first cycle after release.
  - Phase counter cleared, raw samples cleared, debounce counters cleared.
- Reset mid-frame: the partial frame is discarded and no outputs update.
- FSM states: GAP, P0..P7.
  - select = 1 in GAP, P0, P2, P4, P6.
  - select = 0 in P1, P3, P5, P7.
  - select is registered and changes on the first cycle of each phase.
- Each Pn lasts exactly PHASE_CYCLES cycles. The phase counter runs 0..PHASE_CYCLES-1 and wraps to 0 on each phase change.
- GAP lasts GAP_CYCLES cycles. On GAP exit: go to P0 if enable=1, otherwise stay in GAP with the counter held at its terminal value.
- enable is sampled only at GAP exit; deasserting it mid-frame does not truncate the frame.
- Frame length = 8*PHASE_CYCLES + GAP_CYCLES cycles.
- All pins are sampled on the last cycle of the phase (counter == PHASE_CYCLES-1) and inverted (pin low = 1):
  - P1: a <- A_B, start <- START_C.
  - P2: up <- UP_Z, down <- DOWN_Y, left <- LEFT_X, right <- RIGHT_MODE, b <- A_B, c <- START_C.
  - P5: det <- (UP_Z==0 && DOWN_Y==0).
  - P6: z <- UP_Z, y <- DOWN_Y, x <- LEFT_X, mode <- RIGHT_MODE.
  - P0, P3, P4, P7: no sampling.
- Raw frame: if det=0, force x, y, z, mode to 0 for that pad.
- End of frame, on the edge ending the last cycle of P7:
  - six_button[p] <= det.
  - Debounce, per pad:
    - If raw == previous raw, the counter increments, saturating at 15; otherwise the counter resets to 0.
    - buttons_p <= raw when counter+1 >= DEBOUNCE_FRAMES, where counter+1 counts the current frame.
    - DEBOUNCE_FRAMES=1 therefore updates every frame.
  - pressed_p <= new_buttons_p & ~old_buttons_p.
  - frame_done <= 1.
- pressed and frame_done are high for exactly one cycle (the first GAP cycle) and are 0 at all other times.
- buttons and six_button hold their values between frame updates.
- Pads are fully independent; one pad's pins never affect another pad's outputs.
- A pad that is disconnected (pins pulled high) reads all 0 with six_button=0.

Test Plan:
Simulation parameters for all scenarios: PHASE_CYCLES=4, GAP_CYCLES=8, DEBOUNCE_FRAMES=2, NUM_PADS=2. Frame = 40 cycles.
- Reset, then enable=1:
  - select: 1 for 1 cycle, then P0..P7 toggling 1,0,1,0,1,0,1,0 every 4 cycles, then 8 cycles high.
  - frame_done pulses 1 cycle every 40 cycles.
- Pad0 is a 3-button pad holding A:
  - Stimulus: A_B low during select=0 phases; UP/DOWN high in P5.
  - After frame 2: buttons[11:0]=12'h080, pressed[11:0]=12'h080 for 1 cycle, six_button[0]=0.
  - Frame 3: pressed=0, buttons unchanged.
- Pad1 is a 6-button pad holding X and Mode:
  - Stimulus: UP/DOWN low in P5; LEFT_X and RIGHT_MODE low in P6.
  - After frame 2: buttons[23:12]=12'h011, six_button[1]=1, pad0 bits unaffected.
- Glitch on Start for a single frame: buttons stay 0, pressed never asserts.
- enable deasserted in P3: the frame completes, frame_done pulses once, then select stays 1 indefinitely. Re-asserting enable starts P0 at the next GAP exit.
- reset_fixed pulled low in P6 of frame 2: all outputs 0 on the next cycle, no frame_done for the aborted frame, and the debounce count restarts from zero.

Source files
------------

// File: rtl/genesis_pad_scanner_if.sv
// rtl/genesis_pad_scanner_if.sv - pad pins in, select line and per-pad results out
// master is the scanner side; slave is the pad/consumer side.
interface genesis_pad_scanner_if #(
  parameter int NUM_PADS = 2
);
  logic [NUM_PADS-1:0]    PIN_UP_Z;
  logic [NUM_PADS-1:0]    PIN_DOWN_Y;
  logic [NUM_PADS-1:0]    PIN_LEFT_X;
  logic [NUM_PADS-1:0]    PIN_RIGHT_MODE;
  logic [NUM_PADS-1:0]    PIN_A_B;
  logic [NUM_PADS-1:0]    PIN_START_C;
  logic                   select;
  logic [12*NUM_PADS-1:0] buttons;
  logic [12*NUM_PADS-1:0] pressed;
  logic [NUM_PADS-1:0]    six_button;
  logic                   frame_done;

  modport master (
    input  PIN_UP_Z, PIN_DOWN_Y, PIN_LEFT_X, PIN_RIGHT_MODE, PIN_A_B, PIN_START_C,
    output select, buttons, pressed, six_button, frame_done
  );

  modport slave (
    output PIN_UP_Z, PIN_DOWN_Y, PIN_LEFT_X, PIN_RIGHT_MODE, PIN_A_B, PIN_START_C,
    input  select, buttons, pressed, six_button, frame_done
  );
endinterface

// File: rtl/genesis_pad_scanner.sv
// rtl/genesis_pad_scanner.sv - multi-pad Genesis 3/6-button scanner
// One shared select line, per-pad 6-button detect, frame debounce and press pulses.
module genesis_pad_scanner #(
  parameter int NUM_PADS        = 2,
  parameter int PHASE_CYCLES    = 1000,
  parameter int GAP_CYCLES      = 12000,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset_fixed,
  input  logic                  enable,
  genesis_pad_scanner_if.master pads
);

  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    DB_NEED    = 5'(DEBOUNCE_FRAMES);

  localparam int B_UP    = 11;
  localparam int B_DOWN  = 10;
  localparam int B_LEFT  = 9;
  localparam int B_RIGHT = 8;
  localparam int B_A     = 7;
  localparam int B_B     = 6;
  localparam int B_C     = 5;
  localparam int B_X     = 4;
  localparam int B_Y     = 3;
  localparam int B_Z     = 2;
  localparam int B_START = 1;
  localparam int B_MODE  = 0;

  // Extra buttons only a 6-button pad can report.
  localparam logic [11:0] SIX_ONLY = 12'h01D;

  typedef enum logic [3:0] {
    S_GAP, S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7
  } state_t;

  state_t                 state_q;
  logic [PW-1:0]          phase_cnt_q;
  logic [GW-1:0]          gap_cnt_q;
  logic                   select_q;
  logic                   frame_done_q;
  logic [12*NUM_PADS-1:0] buttons_q;
  logic [12*NUM_PADS-1:0] pressed_q;
  logic [NUM_PADS-1:0]    six_q;
  logic [NUM_PADS-1:0]    det_q;
  logic [11:0]            raw_q      [NUM_PADS];
  logic [11:0]            prev_raw_q [NUM_PADS];
  logic [3:0]             db_cnt_q   [NUM_PADS];

  logic [11:0]            frame_raw_d [NUM_PADS];
  logic [3:0]             db_cnt_d    [NUM_PADS];
  logic [12*NUM_PADS-1:0] buttons_d;
  logic [12*NUM_PADS-1:0] pressed_d;

  // End-of-frame results, committed only on the last cycle of P7.
  always_comb begin
    buttons_d = buttons_q;
    pressed_d = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      frame_raw_d[p] = det_q[p] ? raw_q[p] : (raw_q[p] & ~SIX_ONLY);
      if (frame_raw_d[p] != prev_raw_q[p]) begin
        db_cnt_d[p] = 4'd0;
      end else if (db_cnt_q[p] == 4'hF) begin
        db_cnt_d[p] = 4'hF;
      end else begin
        db_cnt_d[p] = db_cnt_q[p] + 4'd1;
      end
      if (({1'b0, db_cnt_d[p]} + 5'd1) >= DB_NEED) begin
        buttons_d[12*p +: 12] = frame_raw_d[p];
      end
      pressed_d[12*p +: 12] = buttons_d[12*p +: 12] & ~buttons_q[12*p +: 12];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_fixed) begin
      state_q      <= S_GAP;
      gap_cnt_q    <= GAP_LAST;
      phase_cnt_q  <= '0;
      select_q     <= 1'b1;
      frame_done_q <= 1'b0;
      buttons_q    <= '0;
      pressed_q    <= '0;
      six_q        <= '0;
      det_q        <= '0;
      for (int p = 0; p < NUM_PADS; p++) begin
        raw_q[p]      <= '0;
        prev_raw_q[p] <= '0;
        db_cnt_q[p]   <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      pressed_q    <= '0;
      if (state_q == S_GAP) begin
        // Terminal count is held while enable is low, so re-enabling starts P0 on the next edge.
        if (gap_cnt_q == GAP_LAST) begin
          if (enable) begin
            state_q     <= S_P0;
            phase_cnt_q <= '0;
            select_q    <= 1'b1;
          end
        end else begin
          gap_cnt_q <= gap_cnt_q + 1'b1;
        end
      end else if (phase_cnt_q != PHASE_LAST) begin
        phase_cnt_q <= phase_cnt_q + 1'b1;
      end else begin
        phase_cnt_q <= '0;
        for (int p = 0; p < NUM_PADS; p++) begin
          case (state_q)
            S_P1: begin
              raw_q[p][B_A]     <= ~pads.PIN_A_B[p];
              raw_q[p][B_START] <= ~pads.PIN_START_C[p];
            end
            S_P2: begin
              raw_q[p][B_UP]    <= ~pads.PIN_UP_Z[p];
              raw_q[p][B_DOWN]  <= ~pads.PIN_DOWN_Y[p];
              raw_q[p][B_LEFT]  <= ~pads.PIN_LEFT_X[p];
              raw_q[p][B_RIGHT] <= ~pads.PIN_RIGHT_MODE[p];
              raw_q[p][B_B]     <= ~pads.PIN_A_B[p];
              raw_q[p][B_C]     <= ~pads.PIN_START_C[p];
            end
            S_P5: det_q[p] <= ~pads.PIN_UP_Z[p] & ~pads.PIN_DOWN_Y[p];
            S_P6: begin
              raw_q[p][B_Z]    <= ~pads.PIN_UP_Z[p];
              raw_q[p][B_Y]    <= ~pads.PIN_DOWN_Y[p];
              raw_q[p][B_X]    <= ~pads.PIN_LEFT_X[p];
              raw_q[p][B_MODE] <= ~pads.PIN_RIGHT_MODE[p];
            end
            default: ;
          endcase
        end
        if (state_q == S_P7) begin
          state_q      <= S_GAP;
          gap_cnt_q    <= '0;
          select_q     <= 1'b1;
          frame_done_q <= 1'b1;
          buttons_q    <= buttons_d;
          pressed_q    <= pressed_d;
          six_q        <= det_q;
          for (int p = 0; p < NUM_PADS; p++) begin
            prev_raw_q[p] <= frame_raw_d[p];
            db_cnt_q[p]   <= db_cnt_d[p];
          end
        end else begin
          // P0..P7 alternate high/low, so the next phase's select is the inverse.
          state_q  <= state_t'(state_q + 4'd1);
          select_q <= ~select_q;
        end
      end
    end
  end

  assign pads.select     = select_q;
  assign pads.buttons    = buttons_q;
  assign pads.pressed    = pressed_q;
  assign pads.six_button = six_q;
  assign pads.frame_done = frame_done_q;

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// tb/tb_genesis_pad_scanner.sv - self-checking bench for genesis_pad_scanner
// Emulated 3/6-button pads drive the pins; a frame-level model predicts the outputs.
module tb_genesis_pad_scanner;
  localparam int NP = 2;
  localparam int PH = 4;
  localparam int GP = 8;
  localparam int DB = 2;
  localparam int FRAME = 8 * PH + GP;
  localparam logic [11:0] XYZM = 12'h01D;

  logic clk = 1'b0;
  logic reset_fixed = 1'b0;
  logic enable = 1'b0;

  genesis_pad_scanner_if #(.NUM_PADS(NP)) pads ();

  genesis_pad_scanner #(
    .NUM_PADS(NP), .PHASE_CYCLES(PH), .GAP_CYCLES(GP), .DEBOUNCE_FRAMES(DB)
  ) dut (
    .clk(clk), .reset_fixed(reset_fixed), .enable(enable), .pads(pads)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] held [NP];
  bit six_cfg [NP];
  bit conn_cfg [NP];

  // Pad emulator: counts select low pulses since the last long high period.
  int lows = 0;
  int high_run = 0;
  logic [3:0] udlr;
  logic ab, sc;
  always @(negedge clk) begin
    if (pads.select === 1'b1) begin
      high_run = high_run + 1;
      if (high_run >= 6) lows = 0;
    end else begin
      if (high_run > 0) lows = lows + 1;
      high_run = 0;
    end
    for (int p = 0; p < NP; p++) begin
      if (!conn_cfg[p]) begin
        udlr = 4'hF; ab = 1'b1; sc = 1'b1;
      end else if (pads.select === 1'b1) begin
        if (six_cfg[p] && lows == 3) udlr = ~{held[p][2], held[p][3], held[p][4], held[p][0]};
        else udlr = ~held[p][11:8];
        ab = ~held[p][6]; sc = ~held[p][5];
      end else begin
        if (six_cfg[p] && lows == 3) udlr = 4'h0;
        else if (six_cfg[p] && lows == 4) udlr = 4'hF;
        else udlr = {~held[p][11], ~held[p][10], 2'b00};
        ab = ~held[p][7]; sc = ~held[p][1];
      end
      pads.PIN_UP_Z[p]       = udlr[3];
      pads.PIN_DOWN_Y[p]     = udlr[2];
      pads.PIN_LEFT_X[p]     = udlr[1];
      pads.PIN_RIGHT_MODE[p] = udlr[0];
      pads.PIN_A_B[p]        = ab;
      pads.PIN_START_C[p]    = sc;
    end
  end

  // Frame-level reference: the debounced level follows the raw frame once the
  // last DB frames (history starts with one all-zero frame) agree.
  logic [11:0] hist [NP][$];
  logic [12*NP-1:0] exp_buttons, exp_pressed;
  logic [NP-1:0] exp_six;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      hist[p].delete();
      hist[p].push_back(12'h000);
    end
    exp_buttons = '0; exp_pressed = '0; exp_six = '0;
  endtask

  task automatic model_frame();
    logic [11:0] raw, old;
    int run;
    for (int p = 0; p < NP; p++) begin
      if (!conn_cfg[p]) raw = 12'h000;
      else if (six_cfg[p]) raw = held[p];
      else raw = held[p] & ~XYZM;
      hist[p].push_back(raw);
      run = 0;
      for (int i = hist[p].size() - 1; i >= 0; i--) begin
        if (hist[p][i] != raw) break;
        run++;
      end
      old = exp_buttons[12*p +: 12];
      if (run >= DB) exp_buttons[12*p +: 12] = raw;
      exp_pressed[12*p +: 12] = exp_buttons[12*p +: 12] & ~old;
      exp_six[p] = conn_cfg[p] && six_cfg[p];
    end
  endtask

  task automatic set_cfg(input logic [11:0] h0, input bit s0, input logic [11:0] h1, input bit s1);
    held[0] = h0; six_cfg[0] = s0; conn_cfg[0] = 1'b1;
    held[1] = h1; six_cfg[1] = s1; conn_cfg[1] = 1'b1;
  endtask

  task automatic do_reset();
    reset_fixed = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset_fixed = 1'b1;
  endtask

  task automatic wait_frame(output bit ok, output int cycles, output logic [12*NP-1:0] prs_seen);
    ok = 1'b0; cycles = 0; prs_seen = '0;
    while (!ok && cycles < 4 * FRAME) begin
      @(negedge clk);
      cycles++;
      prs_seen |= pads.pressed;
      if (pads.frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    set_cfg(12'h000, 1'b0, 12'h000, 1'b0);
    enable = 1'b1;
    reset_fixed = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pads.select !== 1'b1) begin n_bad++; $display("FAIL reset_select got %b want 1", pads.select); end
    n_cmp++; if (pads.buttons !== '0) begin n_bad++; $display("FAIL reset_buttons got %h want 0", pads.buttons); end
    n_cmp++; if (pads.pressed !== '0) begin n_bad++; $display("FAIL reset_pressed got %h want 0", pads.pressed); end
    n_cmp++; if (pads.six_button !== '0) begin n_bad++; $display("FAIL reset_six got %b want 0", pads.six_button); end
    n_cmp++; if (pads.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", pads.frame_done); end
  endtask

  task automatic test_select_timing();
    int f;
    logic exp_sel, exp_fd;
    model_reset();
    reset_fixed = 1'b1;
    for (int n = 1; n <= 2 * FRAME; n++) begin
      @(negedge clk);
      f = (n - 1) % FRAME;
      exp_sel = (f < 8 * PH) ? (((f / PH) % 2) == 0) : 1'b1;
      exp_fd = (f == 8 * PH);
      n_cmp++; if (pads.select !== exp_sel) begin n_bad++; $display("FAIL select_timing cycle %0d got %b want %b", n, pads.select, exp_sel); end
      n_cmp++; if (pads.frame_done !== exp_fd) begin n_bad++; $display("FAIL frame_done_timing cycle %0d got %b want %b", n, pads.frame_done, exp_fd); end
    end
  endtask

  task automatic test_pad_types();
    bit ok; int cyc; logic [12*NP-1:0] seen;
    set_cfg(12'h080, 1'b0, 12'h011, 1'b1);
    do_reset();
    for (int fr = 1; fr <= 3; fr++) begin
      wait_frame(ok, cyc, seen);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL pad_frame_timeout frame %0d got none want frame_done", fr); end
      model_frame();
      n_cmp++; if (pads.buttons !== exp_buttons) begin n_bad++; $display("FAIL pad_buttons frame %0d got %h want %h", fr, pads.buttons, exp_buttons); end
      n_cmp++; if (pads.six_button !== 2'b10) begin n_bad++; $display("FAIL pad_six frame %0d got %b want 10", fr, pads.six_button); end
      if (fr == 2) begin
        n_cmp++; if (pads.buttons !== 24'h011080) begin n_bad++; $display("FAIL pad_buttons_f2 got %h want 011080", pads.buttons); end
        n_cmp++; if (pads.pressed !== 24'h011080) begin n_bad++; $display("FAIL pad_pressed_f2 got %h want 011080", pads.pressed); end
        @(negedge clk);
        n_cmp++; if (pads.pressed !== '0) begin n_bad++; $display("FAIL pad_pressed_one_cycle got %h want 0", pads.pressed); end
        n_cmp++; if (pads.frame_done !== 1'b0) begin n_bad++; $display("FAIL pad_frame_done_one_cycle got %b want 0", pads.frame_done); end
      end
      if (fr == 3) begin
        n_cmp++; if (pads.pressed !== '0) begin n_bad++; $display("FAIL pad_pressed_f3 got %h want 0", pads.pressed); end
        n_cmp++; if (pads.buttons !== 24'h011080) begin n_bad++; $display("FAIL pad_buttons_f3 got %h want 011080", pads.buttons); end
      end
    end
  endtask

  task automatic test_glitch();
    bit ok; int cyc; logic [12*NP-1:0] seen;
    set_cfg(12'h002, 1'b0, 12'h000, 1'b0);
    do_reset();
    for (int fr = 1; fr <= 3; fr++) begin
      wait_frame(ok, cyc, seen);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL glitch_timeout frame %0d got none want frame_done", fr); end
      held[0] = 12'h000;
      n_cmp++; if (pads.buttons !== '0) begin n_bad++; $display("FAIL glitch_buttons frame %0d got %h want 0", fr, pads.buttons); end
      n_cmp++; if (seen !== '0) begin n_bad++; $display("FAIL glitch_pressed frame %0d got %h want 0", fr, seen); end
    end
  endtask

  task automatic rand_cfg(input bit first);
    for (int p = 0; p < NP; p++) begin
      if (first || $urandom_range(1, 0) == 1) held[p] = 12'($urandom);
      if (first) begin
        six_cfg[p] = 1'($urandom);
        conn_cfg[p] = ($urandom_range(3, 0) != 0);
      end else begin
        if ($urandom_range(7, 0) == 0) six_cfg[p] = !six_cfg[p];
        if ($urandom_range(7, 0) == 0) conn_cfg[p] = !conn_cfg[p];
      end
      // A d-pad cannot press up and down together on a 3-button pad.
      if (!six_cfg[p] && held[p][11] && held[p][10]) held[p][10] = 1'b0;
    end
  endtask

  task automatic test_random();
    bit ok; int cyc; logic [12*NP-1:0] seen;
    rand_cfg(1'b1);
    do_reset();
    for (int fr = 1; fr <= 16; fr++) begin
      wait_frame(ok, cyc, seen);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_timeout frame %0d got none want frame_done", fr); end
      model_frame();
      n_cmp++; if (pads.buttons !== exp_buttons) begin n_bad++; $display("FAIL rand_buttons frame %0d got %h want %h", fr, pads.buttons, exp_buttons); end
      n_cmp++; if (pads.pressed !== exp_pressed) begin n_bad++; $display("FAIL rand_pressed frame %0d got %h want %h", fr, pads.pressed, exp_pressed); end
      n_cmp++; if (pads.six_button !== exp_six) begin n_bad++; $display("FAIL rand_six frame %0d got %b want %b", fr, pads.six_button, exp_six); end
      rand_cfg(1'b0);
    end
  endtask

  task automatic test_enable_pause();
    bit ok; int cyc; logic [12*NP-1:0] seen;
    int first_low, fd_at;
    set_cfg(12'h080, 1'b0, 12'h000, 1'b0);
    enable = 1'b1;
    do_reset();
    wait_frame(ok, cyc, seen);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL en_first_timeout got none want frame_done"); end
    model_frame();
    repeat (21) @(negedge clk);
    enable = 1'b0;
    wait_frame(ok, cyc, seen);
    n_cmp++; if (cyc !== 19) begin n_bad++; $display("FAIL en_frame_completes got %0d cycles want 19", cyc); end
    model_frame();
    n_cmp++; if (pads.buttons !== exp_buttons) begin n_bad++; $display("FAIL en_buttons got %h want %h", pads.buttons, exp_buttons); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++; if (pads.select !== 1'b1 || pads.frame_done !== 1'b0) begin
        n_bad++; $display("FAIL en_parked cycle %0d got sel=%b fd=%b want sel=1 fd=0", i, pads.select, pads.frame_done);
      end
    end
    enable = 1'b1;
    first_low = -1; fd_at = -1;
    for (int k = 1; k <= 2 * FRAME && fd_at < 0; k++) begin
      @(negedge clk);
      if (first_low < 0 && pads.select === 1'b0) first_low = k;
      if (pads.frame_done === 1'b1) fd_at = k;
    end
    n_cmp++; if (first_low !== 5) begin n_bad++; $display("FAIL en_restart_p1 got %0d want 5", first_low); end
    n_cmp++; if (fd_at !== 33) begin n_bad++; $display("FAIL en_restart_frame_done got %0d want 33", fd_at); end
    model_frame();
    n_cmp++; if (pads.buttons !== exp_buttons || pads.pressed !== exp_pressed) begin
      n_bad++; $display("FAIL en_resume_outputs got %h/%h want %h/%h", pads.buttons, pads.pressed, exp_buttons, exp_pressed);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok; int cyc; logic [12*NP-1:0] seen;
    set_cfg(12'h080, 1'b0, 12'h011, 1'b1);
    enable = 1'b1;
    do_reset();
    wait_frame(ok, cyc, seen);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_first_timeout got none want frame_done"); end
    model_frame();
    repeat (33) @(negedge clk);
    n_cmp++; if (pads.select !== 1'b1) begin n_bad++; $display("FAIL mid_in_p6 got sel=%b want 1", pads.select); end
    reset_fixed = 1'b0;
    @(negedge clk);
    n_cmp++; if ({pads.buttons, pads.pressed, pads.six_button, pads.frame_done, pads.select} !== {{(24*NP+NP+1){1'b0}}, 1'b1}) begin
      n_bad++; $display("FAIL mid_reset_outputs got b=%h p=%h s=%b fd=%b sel=%b want all 0 sel=1",
                        pads.buttons, pads.pressed, pads.six_button, pads.frame_done, pads.select);
    end
    @(negedge clk);
    n_cmp++; if (pads.frame_done !== 1'b0) begin n_bad++; $display("FAIL mid_no_frame_done got %b want 0", pads.frame_done); end
    model_reset();
    reset_fixed = 1'b1;
    wait_frame(ok, cyc, seen);
    n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL mid_restart_latency got %0d want 33", cyc); end
    model_frame();
    n_cmp++; if (pads.buttons !== 24'h000000) begin n_bad++; $display("FAIL mid_debounce_restart got %h want 000000", pads.buttons); end
    n_cmp++; if (pads.six_button !== exp_six) begin n_bad++; $display("FAIL mid_six got %b want %b", pads.six_button, exp_six); end
    wait_frame(ok, cyc, seen);
    model_frame();
    n_cmp++; if (pads.buttons !== 24'h011080 || pads.buttons !== exp_buttons) begin
      n_bad++; $display("FAIL mid_second_frame got %h want 011080", pads.buttons);
    end
  endtask

  initial begin
    test_reset();
    test_select_timing();
    test_pad_types();
    test_glitch();
    test_random();
    test_enable_pause();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want summary");
    $fatal(1);
  end

endmodule
